// File: rtl/ltssm_detect_polling_ctrl.sv
// LTSSM front end: Detect.Quiet/Active, Polling.Active/Configuration, then a
// link-trained hand-off state. Drives the shared Timer, PIPE rx-detect and TX OS requests.
module ltssm_detect_polling_ctrl #(
  parameter int unsigned TS1_TX_MIN   = 1024,
  parameter int unsigned RX_CONSEC    = 8,
  parameter int unsigned TS2_TX_AFTER = 16,
  parameter int unsigned CNT_WIDTH    = 11
) (
  input  logic       Pclk,
  input  logic       Reset,
  input  logic       RxElecIdle,
  input  logic       PhyStatus,
  input  logic [2:0] RxStatus,
  input  logic       TS1Sent,
  input  logic       TS2Sent,
  input  logic       TS1Rcvd,
  input  logic       TS2Rcvd,
  input  logic       OtherRcvd,
  input  logic       TimeOut,
  output logic       TimerStart,
  output logic       TimerEnable,
  output logic [2:0] TimerIntervalCode,
  output logic       TxDetectRx,
  output logic       SendTS1,
  output logic       SendTS2,
  output logic       LinkUp,
  output logic [2:0] State
);

  localparam logic [CNT_WIDTH-1:0] TX1_MAX  = CNT_WIDTH'(TS1_TX_MIN);
  localparam logic [CNT_WIDTH-1:0] RX_MAX   = CNT_WIDTH'(RX_CONSEC);
  localparam logic [CNT_WIDTH-1:0] TX2_MAX  = CNT_WIDTH'(TS2_TX_AFTER);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [2:0]           RX_FOUND = 3'b011;

  typedef enum logic [2:0] {
    DQUIET  = 3'd0,
    DACTIVE = 3'd1,
    PACTIVE = 3'd2,
    PCONFIG = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] tx1_cnt_q, tx1_cnt_d;
  logic [CNT_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
  logic [CNT_WIDTH-1:0] tx2_cnt_q, tx2_cnt_d;
  logic                 seen_ts2_q, seen_ts2_d;

  logic                 timer_start_q;
  logic                 timer_en_q;
  logic [2:0]           interval_q;
  logic                 tx_detect_q;
  logic                 send_ts1_q;
  logic                 send_ts2_q;
  logic                 link_up_q;
  logic                 timeout_ok;

  function automatic logic [2:0] interval_code(input state_e s);
    logic [2:0] code;
    case (s)
      DQUIET:  code = 3'b001;
      DACTIVE: code = 3'b100;
      PACTIVE: code = 3'b010;
      PCONFIG: code = 3'b011;
      DONE:    code = 3'b000;
      default: code = 3'b001;
    endcase
    return code;
  endfunction

  // The timer is still restarting during the entry cycle, so its TimeOut is stale then.
  assign timeout_ok = TimeOut & ~timer_start_q;

  // Next state and ordered-set counters.
  always_comb begin
    state_d    = state_q;
    tx1_cnt_d  = tx1_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    tx2_cnt_d  = tx2_cnt_q;
    seen_ts2_d = seen_ts2_q;

    case (state_q)
      DQUIET: begin
        if (timeout_ok || (!RxElecIdle && !timer_start_q)) begin
          state_d = DACTIVE;
        end
      end

      DACTIVE: begin
        if (PhyStatus) begin
          state_d = (RxStatus == RX_FOUND) ? PACTIVE : DQUIET;
        end else if (timeout_ok) begin
          state_d = DQUIET;
        end
      end

      PACTIVE: begin
        if (TS1Sent && (tx1_cnt_q != TX1_MAX)) begin
          tx1_cnt_d = tx1_cnt_q + CNT_ONE;
        end
        if (OtherRcvd) begin
          rx_cnt_d = '0;
        end else if ((TS1Rcvd || TS2Rcvd) && (rx_cnt_q != RX_MAX)) begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
        if ((tx1_cnt_q == TX1_MAX) && (rx_cnt_q == RX_MAX)) begin
          state_d = PCONFIG;
        end else if (timeout_ok) begin
          state_d = DQUIET;
        end
      end

      PCONFIG: begin
        if (TS1Rcvd || OtherRcvd) begin
          rx_cnt_d = '0;
        end else if (TS2Rcvd && (rx_cnt_q != RX_MAX)) begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
        if (TS2Rcvd) begin
          seen_ts2_d = 1'b1;
        end
        // Only TS2s sent after the partner's first TS2 is seen count toward exit.
        if (TS2Sent && seen_ts2_q && (tx2_cnt_q != TX2_MAX)) begin
          tx2_cnt_d = tx2_cnt_q + CNT_ONE;
        end
        if ((rx_cnt_q == RX_MAX) && (tx2_cnt_q == TX2_MAX)) begin
          state_d = DONE;
        end else if (timeout_ok) begin
          state_d = DQUIET;
        end
      end

      DONE: begin
        state_d = DONE;
      end

      default: begin
        state_d = DQUIET;
      end
    endcase

    if (state_d != state_q) begin
      tx1_cnt_d  = '0;
      rx_cnt_d   = '0;
      tx2_cnt_d  = '0;
      seen_ts2_d = 1'b0;
    end
  end

  // State, counters and outputs; outputs follow the state being entered.
  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      state_q       <= DQUIET;
      tx1_cnt_q     <= '0;
      rx_cnt_q      <= '0;
      tx2_cnt_q     <= '0;
      seen_ts2_q    <= 1'b0;
      timer_start_q <= 1'b1;
      timer_en_q    <= 1'b1;
      interval_q    <= 3'b001;
      tx_detect_q   <= 1'b0;
      send_ts1_q    <= 1'b0;
      send_ts2_q    <= 1'b0;
      link_up_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx1_cnt_q     <= tx1_cnt_d;
      rx_cnt_q      <= rx_cnt_d;
      tx2_cnt_q     <= tx2_cnt_d;
      seen_ts2_q    <= seen_ts2_d;
      timer_start_q <= (state_d != state_q);
      timer_en_q    <= (state_d != DONE);
      interval_q    <= interval_code(state_d);
      tx_detect_q   <= (state_d == DACTIVE);
      send_ts1_q    <= (state_d == PACTIVE);
      send_ts2_q    <= (state_d == PCONFIG);
      link_up_q     <= (state_d == DONE);
    end
  end

  assign State             = state_q;
  assign TimerStart        = timer_start_q;
  assign TimerEnable       = timer_en_q;
  assign TimerIntervalCode = interval_q;
  assign TxDetectRx        = tx_detect_q;
  assign SendTS1           = send_ts1_q;
  assign SendTS2           = send_ts2_q;
  assign LinkUp            = link_up_q;

endmodule

// File: tb/tb_ltssm_detect_polling_ctrl.sv
// Directed + randomized bench for ltssm_detect_polling_ctrl, checked every cycle
// against a behavioural model of the link-training rules.
module tb_ltssm_detect_polling_ctrl;

  localparam int TS1_TX_MIN   = 1024;
  localparam int RX_CONSEC    = 8;
  localparam int TS2_TX_AFTER = 16;

  logic       Pclk = 1'b0;
  logic       Reset;
  logic       RxElecIdle;
  logic       PhyStatus;
  logic [2:0] RxStatus;
  logic       TS1Sent, TS2Sent, TS1Rcvd, TS2Rcvd, OtherRcvd, TimeOut;
  logic       TimerStart, TimerEnable, TxDetectRx, SendTS1, SendTS2, LinkUp;
  logic [2:0] TimerIntervalCode;
  logic [2:0] State;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: phase number 0..4 plus plain integer counters.
  int m_state, m_tx1, m_rx, m_tx2;
  bit m_start, m_seen;

  ltssm_detect_polling_ctrl dut (
    .Pclk(Pclk), .Reset(Reset), .RxElecIdle(RxElecIdle), .PhyStatus(PhyStatus),
    .RxStatus(RxStatus), .TS1Sent(TS1Sent), .TS2Sent(TS2Sent), .TS1Rcvd(TS1Rcvd),
    .TS2Rcvd(TS2Rcvd), .OtherRcvd(OtherRcvd), .TimeOut(TimeOut),
    .TimerStart(TimerStart), .TimerEnable(TimerEnable),
    .TimerIntervalCode(TimerIntervalCode), .TxDetectRx(TxDetectRx),
    .SendTS1(SendTS1), .SendTS2(SendTS2), .LinkUp(LinkUp), .State(State)
  );

  always #5 Pclk = ~Pclk;

  function automatic int sat_inc(input int v, input int lim);
    return (v + 1 > lim) ? lim : v + 1;
  endfunction

  function automatic void model_edge();
    int ns;
    bit to;
    if (!Reset) begin
      m_state = 0; m_start = 1'b1; m_tx1 = 0; m_rx = 0; m_tx2 = 0; m_seen = 1'b0;
      return;
    end
    to = TimeOut && !m_start;
    ns = m_state;
    case (m_state)
      0: if (to || (!RxElecIdle && !m_start)) ns = 1;
      1: if (PhyStatus) ns = (RxStatus == 3'b011) ? 2 : 0;
         else if (to) ns = 0;
      2: if (m_tx1 == TS1_TX_MIN && m_rx == RX_CONSEC) ns = 3;
         else if (to) ns = 0;
      3: if (m_rx == RX_CONSEC && m_tx2 == TS2_TX_AFTER) ns = 4;
         else if (to) ns = 0;
      4: ns = 4;
      default: ns = 0;
    endcase
    if (ns != m_state) begin
      m_tx1 = 0; m_rx = 0; m_tx2 = 0; m_seen = 1'b0;
    end else if (m_state == 2) begin
      if (TS1Sent) m_tx1 = sat_inc(m_tx1, TS1_TX_MIN);
      if (OtherRcvd) m_rx = 0;
      else if (TS1Rcvd || TS2Rcvd) m_rx = sat_inc(m_rx, RX_CONSEC);
    end else if (m_state == 3) begin
      if (TS1Rcvd || OtherRcvd) m_rx = 0;
      else if (TS2Rcvd) m_rx = sat_inc(m_rx, RX_CONSEC);
      if (TS2Sent && m_seen) m_tx2 = sat_inc(m_tx2, TS2_TX_AFTER);
      if (TS2Rcvd) m_seen = 1'b1;
    end
    m_start = (ns != m_state);
    m_state = ns;
  endfunction

  function automatic logic [11:0] model_outputs();
    logic [2:0] code;
    case (m_state)
      0: code = 3'b001;
      1: code = 3'b100;
      2: code = 3'b010;
      3: code = 3'b011;
      default: code = 3'b000;
    endcase
    return {3'(m_state), m_start, (m_state != 4), code, (m_state == 1),
            (m_state == 2), (m_state == 3), (m_state == 4)};
  endfunction

  task automatic check(input string tag);
    logic [11:0] obs, exp;
    obs = {State, TimerStart, TimerEnable, TimerIntervalCode, TxDetectRx,
           SendTS1, SendTS2, LinkUp};
    exp = model_outputs();
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed {st,start,en,code,det,ts1,ts2,up}=%h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] want);
    n_assert++;
    assert (State === want) else begin
      n_fail++;
      $error("FAIL %s: observed State=%0d expected %0d", tag, State, want);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge Pclk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic quiet();
    PhyStatus = 1'b0; RxStatus = 3'b000; TS1Sent = 1'b0; TS2Sent = 1'b0;
    TS1Rcvd = 1'b0; TS2Rcvd = 1'b0; OtherRcvd = 1'b0; TimeOut = 1'b0;
  endtask

  // From DQUIET (any sub-cycle) into PACTIVE, past its entry cycle.
  task automatic to_pactive();
    quiet(); tick("pre_detect");
    TimeOut = 1'b1; tick("dquiet_to_dactive");
    quiet(); tick("dactive_wait");
    PhyStatus = 1'b1; RxStatus = 3'b011; tick("dactive_to_pactive");
    quiet(); tick("pactive_entry");
  endtask

  // Random polling traffic until PCONFIG is reached, then past its entry cycle.
  task automatic run_pactive();
    for (int i = 0; i < 4000 && m_state == 2; i++) begin
      TS1Sent   = ($urandom_range(3) != 0);
      TS1Rcvd   = ($urandom_range(1) == 1);
      TS2Rcvd   = ($urandom_range(3) == 0);
      OtherRcvd = ($urandom_range(15) == 0);
      tick("pactive_random");
    end
    quiet();
    check_state("pactive_exit", 3'd3);
    tick("pconfig_entry");
  endtask

  initial begin
    Reset = 1'b0; RxElecIdle = 1'b1; quiet();
    repeat (3) tick("reset_held");

    Reset = 1'b1; TimeOut = 1'b1; tick("entry_timeout_ignored");
    TimeOut = 1'b0; tick("dquiet_hold");
    TimeOut = 1'b1; tick("dquiet_timeout");
    TimeOut = 1'b1; tick("dactive_entry_timeout_ignored");
    quiet(); PhyStatus = 1'b1; tick("dactive_no_receiver");
    quiet(); RxElecIdle = 1'b0; tick("dquiet_entry_elecidle_ignored");
    tick("dquiet_elecidle_exit");
    RxElecIdle = 1'b1; tick("dactive_wait");
    TimeOut = 1'b1; tick("dactive_timeout");
    TimeOut = 1'b0; tick("dquiet_hold2");
    TimeOut = 1'b1; tick("dquiet_timeout2");
    TimeOut = 1'b0; tick("dactive_wait2");
    PhyStatus = 1'b1; RxStatus = 3'b011; TimeOut = 1'b1; tick("phystatus_beats_timeout");
    quiet(); tick("pactive_entry");

    // Polling.Active timeout after 1000 TS1s
    repeat (1000) begin
      TS1Sent = 1'b1; TS1Rcvd = ($urandom_range(1) == 1);
      tick("pactive_1000");
    end
    quiet(); TimeOut = 1'b1; tick("pactive_timeout");
    quiet(); tick("dquiet_after_timeout");

    to_pactive();
    run_pactive();

    // Polling.Configuration: early TS2s don't count; the one alongside the first TS2Rcvd doesn't either
    repeat (16) begin TS2Sent = 1'b1; tick("pconfig_early_ts2"); end
    quiet(); tick("pconfig_idle");
    for (int i = 0; i < 8; i++) begin
      TS2Rcvd = 1'b1; TS2Sent = (i == 0); tick("pconfig_ts2rcvd");
    end
    quiet();
    repeat (16) begin TS2Sent = 1'b1; tick("pconfig_late_ts2"); end
    quiet(); tick("pconfig_to_done");
    check_state("pconfig_exit", 3'd4);

    repeat (20) begin
      TS1Rcvd = ($urandom_range(1) == 1); TS2Sent = ($urandom_range(1) == 1);
      OtherRcvd = ($urandom_range(1) == 1); TimeOut = ($urandom_range(1) == 1);
      tick("done_hold");
    end
    quiet(); Reset = 1'b0; tick("reset_from_done");
    Reset = 1'b1;

    // Second training run, interrupted by reset inside PCONFIG
    to_pactive();
    run_pactive();
    for (int i = 0; i < 12 && m_state == 3; i++) begin
      TS2Sent   = ($urandom_range(1) == 1);
      TS2Rcvd   = ($urandom_range(1) == 1);
      TS1Rcvd   = ($urandom_range(7) == 0);
      OtherRcvd = ($urandom_range(7) == 0);
      tick("pconfig_random");
    end
    check_state("still_pconfig", 3'd3);
    quiet(); Reset = 1'b0; tick("reset_in_pconfig");
    Reset = 1'b1;

    // Third run: counters start from zero again; PCONFIG timeout
    to_pactive();
    run_pactive();
    TS2Rcvd = 1'b1; tick("pconfig_rcv");
    quiet(); TimeOut = 1'b1; tick("pconfig_timeout");
    quiet(); tick("dquiet_after_pconfig");
    check_state("back_to_dquiet", 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ltssm_detect_polling_ctrl.md
Name: ltssm_detect_polling_ctrl

Overview:
- LTSSM front-end controller covering Detect.Quiet, Detect.Active, Polling.Active and Polling.Configuration, ending in a link-trained hand-off state.
- Consumes the TimeOut of the existing Timer block and drives that timer's Start, Enable and TimerIntervalCode inputs.
- Drives PIPE receiver detection and requests TS1/TS2 ordered-set transmission from the TX ordered-set generator.
- Consumes decoded-ordered-set pulses from the RX side.

Parameters:
TS1_TX_MIN, 1024, TS1s that must be transmitted in Polling.Active before exit
RX_CONSEC, 8, consecutive matching ordered sets required on RX
TS2_TX_AFTER, 16, TS2s transmitted after the first TS2 is received in Polling.Configuration
CNT_WIDTH, 11, width of all ordered-set counters; must hold TS1_TX_MIN

Ports:
Pclk  in  1  PIPE clock
Reset  in  1  synchronous, active-low reset
RxElecIdle  in  1  PIPE electrical idle; 0 means exit from idle detected
PhyStatus  in  1  PIPE completion pulse for receiver detection
RxStatus  in  3  PIPE status; 3'b011 at PhyStatus means receiver present
TS1Sent  in  1  one-cycle pulse per TS1 transmitted
TS2Sent  in  1  one-cycle pulse per TS2 transmitted
TS1Rcvd  in  1  one-cycle pulse per valid TS1 received
TS2Rcvd  in  1  one-cycle pulse per valid TS2 received
OtherRcvd  in  1  one-cycle pulse per any other received ordered set or error
TimeOut  in  1  from Timer
TimerStart  out  1  to Timer Start
TimerEnable  out  1  to Timer Enable
TimerIntervalCode  out  3  to Timer interval select
TxDetectRx  out  1  PIPE receiver-detect request
SendTS1  out  1  request continuous TS1 transmission
SendTS2  out  1  request continuous TS2 transmission
LinkUp  out  1  Polling complete
State  out  3  current state: 0=DQUIET, 1=DACTIVE, 2=PACTIVE, 3=PCONFIG, 4=DONE

Behaviour:
- All outputs are registered.
- Reset values: State=0, TimerStart=1, TimerEnable=1, TimerIntervalCode=3'b001, TxDetectRx=0, SendTS1=0, SendTS2=0, LinkUp=0, all counters 0.
- Reset asserted in any state returns the block to DQUIET with the reset values on the next edge.
- State entry:
  - On every state change, TimerStart=1 for exactly the first cycle in the new state; 0 otherwise.
  - All counters clear on entry.
  - TimeOut is ignored while TimerStart=1.
- Interval code per state: DQUIET 3'b001 (12ms), DACTIVE 3'b100 (2ms), PACTIVE 3'b010 (24ms), PCONFIG 3'b011 (48ms), DONE 3'b000.
- TimerEnable=1 in all states except DONE, where it is 0.
- DQUIET:
  - All TX requests are 0.
  - Go to DACTIVE on TimeOut, or when RxElecIdle=0 (with TimerStart=0).
- DACTIVE:
  - TxDetectRx=1 from the entry cycle until PhyStatus is sampled 1.
  - On PhyStatus=1: RxStatus==3'b011 -> PACTIVE; otherwise -> DQUIET.
  - TimeOut without PhyStatus -> DQUIET. PhyStatus has priority over TimeOut.
- PACTIVE:
  - SendTS1=1.
  - tx1_cnt increments on TS1Sent and saturates at TS1_TX_MIN.
  - rx_cnt increments on TS1Rcvd or TS2Rcvd, saturates at RX_CONSEC, and clears on OtherRcvd. OtherRcvd wins over a same-cycle TS pulse. TS1Rcvd and TS2Rcvd in the same cycle count as one increment.
  - Exit to PCONFIG when registered tx1_cnt==TS1_TX_MIN and rx_cnt==RX_CONSEC. The transition occurs on the edge after the counters reach their thresholds (one cycle latency).
  - TimeOut -> DQUIET. The success condition has priority over TimeOut.
- PCONFIG:
  - SendTS2=1, SendTS1=0.
  - rx_cnt counts TS2Rcvd only, saturates at RX_CONSEC, and clears on TS1Rcvd or OtherRcvd (clear wins).
  - seen_ts2 flag sets on the first TS2Rcvd.
  - tx2_cnt increments on TS2Sent only in cycles where seen_ts2 is already 1, saturating at TS2_TX_AFTER. A TS2Sent in the same cycle as the first TS2Rcvd is not counted.
  - Exit to DONE when rx_cnt==RX_CONSEC and tx2_cnt==TS2_TX_AFTER. Success has priority over TimeOut.
  - TimeOut -> DQUIET.
- DONE:
  - LinkUp=1, SendTS2=0, TimerEnable=0.
  - Held until Reset.
- Encodings 5–7 are unreachable; if entered, go to DQUIET on the next edge.

Test Plan:
- Reset low for 3 cycles, then high with RxElecIdle=1: State=0 and TimerStart=1 in the first cycle; TimeOut pulse -> State=1 with TxDetectRx=1 and TimerIntervalCode=3'b100.
- In DACTIVE, PhyStatus=1 with RxStatus=3'b011 -> State=2, SendTS1=1, code 3'b010. Repeat with RxStatus=3'b000 -> State=0.
- In PACTIVE: 1024 TS1Sent pulses plus 8 TS1Rcvd with one OtherRcvd after the 5th -> no exit until 8 further TS1Rcvd, then State=3 one cycle after the 1024th/final pulse.
- In PACTIVE: 1000 TS1Sent, then TimeOut -> State=0, SendTS1=0, TimerStart=1 for one cycle.
- In PCONFIG: 16 TS2Sent before any TS2Rcvd, then 8 TS2Rcvd, then 16 TS2Sent -> State=4 and LinkUp=1 only after the last 16 pulses; TimerEnable=0.
- Reset asserted while in PCONFIG -> next edge State=0, SendTS2=0, counters 0, TimerIntervalCode=3'b001.
